// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx
//   Write-only I2C target. SCL/SDA are oversampled on clk. The block detects
//   START, STOP and repeated START, matches a 7-bit address with R/W=0, ACKs
//   the address and every data byte, and strobes each received byte out.
//
// Parameters
//   SLAVE_ADDR   7-bit bus address answered to
//   SYNC_STAGES  input synchronizer depth (>= 2)
//
// Ports
//   clk        in     system clock (100 MHz)
//   reset      in     asynchronous reset, active-high
//   scl        in     I2C clock from the master (never stretched here)
//   sda        inout  I2C data, open-drain (driven 0 or released to Z)
//   rx_data    out    last received data byte, held until the next one
//   rx_valid   out    one-cycle strobe, rx_data updated this cycle
//   addr_match out    high from the ACKed address byte until STOP/START
//   busy       out    high from START until STOP
//
// Build option
//   I2C_SLV_GLITCH_FILTER_EN  3-sample majority filter after the synchronizer
//                             (rejects pulses <= 1 clk, adds 2 clk latency)
// ---------------------------------------------------------------------------
module i2c_slave_rx #(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addr_match,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_DATA     = 3'd3,
      ST_DATA_ACK = 3'd4,
      ST_IGNORE   = 3'd5
   } state_t;

   state_t state_q, state_d;

   // Input synchronizers; reset to the idle-bus level so no false edge appears
   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      end
   end

   logic scl_s, sda_s;

`ifdef I2C_SLV_GLITCH_FILTER_EN
   // Majority of the newest synced sample and the two before it
   logic [1:0] scl_hist_q, sda_hist_q;
   logic       scl_filt_q, sda_filt_q;
   logic       scl_raw, sda_raw;

   assign scl_raw = scl_sync_q[SYNC_STAGES-1];
   assign sda_raw = sda_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_hist_q <= 2'b11;
         sda_hist_q <= 2'b11;
         scl_filt_q <= 1'b1;
         sda_filt_q <= 1'b1;
      end else begin
         scl_hist_q <= {scl_hist_q[0], scl_raw};
         sda_hist_q <= {sda_hist_q[0], sda_raw};
         scl_filt_q <= (scl_raw & scl_hist_q[0]) | (scl_raw & scl_hist_q[1]) |
                       (scl_hist_q[0] & scl_hist_q[1]);
         sda_filt_q <= (sda_raw & sda_hist_q[0]) | (sda_raw & sda_hist_q[1]) |
                       (sda_hist_q[0] & sda_hist_q[1]);
      end
   end

   assign scl_s = scl_filt_q;
   assign sda_s = sda_filt_q;
`else
   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

   // Previous sample for edge detection
   logic scl_prev_q, sda_prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   logic scl_rise, scl_fall, start_cond, stop_cond;

   assign scl_rise   =  scl_s & ~scl_prev_q;
   assign scl_fall   = ~scl_s &  scl_prev_q;
   assign start_cond =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
   assign stop_cond  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

   // Datapath registers
   logic [7:0] shift_q, shift_d;
   logic [2:0] cnt_q, cnt_d;
   logic       full_q, full_d;      // 8 bits shifted, waiting for the closing scl_fall
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       addr_match_q, addr_match_d;
   logic       busy_q, busy_d;
   logic       addr_hit;

   assign addr_hit = (shift_q == {SLAVE_ADDR, 1'b0});

   // State register and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         shift_q      <= 8'h00;
         cnt_q        <= 3'd0;
         full_q       <= 1'b0;
         sda_oe_q     <= 1'b0;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         addr_match_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         full_q       <= full_d;
         sda_oe_q     <= sda_oe_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         addr_match_q <= addr_match_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic; bus conditions override any scl edge
   always_comb begin
      state_d = state_q;
      if (stop_cond) begin
         state_d = ST_IDLE;
      end else if (start_cond) begin
         state_d = ST_ADDR;
      end else begin
         case (state_q)
            ST_ADDR:     if (scl_fall && full_q) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
            ST_ADDR_ACK: if (scl_fall) state_d = ST_DATA;
            ST_DATA:     if (scl_fall && full_q) state_d = ST_DATA_ACK;
            ST_DATA_ACK: if (scl_fall) state_d = ST_DATA;
            default:     state_d = state_q;
         endcase
      end
   end

   // Output and datapath next values
   always_comb begin
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      full_d       = full_q;
      sda_oe_d     = sda_oe_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      addr_match_d = addr_match_q;
      busy_d       = busy_q;

      if (stop_cond || start_cond) begin
         busy_d       = start_cond;
         addr_match_d = 1'b0;
         sda_oe_d     = 1'b0;
         cnt_d        = 3'd0;
         full_d       = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_DATA: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + 3'd1;        // wraps to 0 after the 8th bit
                  if (cnt_q == 3'd7) full_d = 1'b1;
               end else if (scl_fall && full_q) begin
                  full_d = 1'b0;
                  if (state_q == ST_ADDR) begin
                     sda_oe_d = addr_hit;
                  end else begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     sda_oe_d   = 1'b1;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d     = 1'b0;
                  addr_match_d = 1'b1;
               end
            end
            ST_DATA_ACK: begin
               if (scl_fall) sda_oe_d = 1'b0;
            end
            default: begin
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   assign sda        = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign addr_match = addr_match_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a behavioural I2C master drives SCL/SDA
// with a pull-up on SDA; received bytes are logged from rx_valid.
module tb_i2c_slave_rx;

   localparam int Q = 20;   // clk cycles per quarter SCL period

   logic       clk = 1'b0;
   logic       reset;
   logic       scl;
   logic       m_sda;        // master SDA: 1 = release, 0 = pull low
   wire        sda;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       addr_match;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int rx_cnt = 0;
   int am_cnt = 0;
   logic [7:0] rx_log [$];

   assign sda = m_sda ? 1'bz : 1'b0;
   pullup (sda);

   i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .scl        (scl),
      .sda        (sda),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .addr_match (addr_match),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         rx_log.push_back(rx_data);
      end
      if (addr_match) am_cnt++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- master primitives ----------------
   task automatic wq(input int n = 1);
      repeat (n * Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wq();
      scl   = 1'b1; wq();
      m_sda = 1'b0; wq();
      scl   = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wq();
      scl   = 1'b1; wq();
      m_sda = 1'b1; wq(2);
   endtask

   task automatic i2c_bit(input logic b);
      m_sda = b; wq();
      scl   = 1'b1; wq(2);
      scl   = 1'b0; wq();
   endtask

   task automatic i2c_bits(input logic [7:0] b, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) i2c_bit(b[i]);
   endtask

   task automatic i2c_ack(output logic ack);
      m_sda = 1'b1; wq();
      scl   = 1'b1; wq();
      ack   = (sda === 1'b0);
      wq();
      scl   = 1'b0; wq();
   endtask

   task automatic i2c_byte(input logic [7:0] b, output logic ack);
      i2c_bits(b, 7, 0);
      i2c_ack(ack);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; scl = 1'b1; m_sda = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      wq();
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      total++; if (addr_match !== 1'b0) begin bad++; $display("FAIL reset_addr_match: got %b want 0", addr_match); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b want 1", sda); end
   endtask

   task automatic test_write();
      logic ack;
      int base;
      base = rx_cnt;
      i2c_start();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy_start: got %b want 1", busy); end
      i2c_byte(8'hA0, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL write_addr_ack: got %b want 1", ack); end
      total++; if (addr_match !== 1'b1) begin bad++; $display("FAIL write_addr_match: got %b want 1", addr_match); end
      i2c_byte(8'h3C, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL write_data_ack: got %b want 1", ack); end
      i2c_stop();
      total++; if (rx_cnt - base !== 1) begin bad++; $display("FAIL write_rx_count: got %0d want 1", rx_cnt - base); end
      total++; if (rx_cnt - base >= 1 && rx_log[base] !== 8'h3C) begin bad++; $display("FAIL write_rx_byte: got %h want 3c", rx_log[base]); end
      total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL write_rx_data_hold: got %h want 3c", rx_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_stop: got %b want 0", busy); end
      total++; if (addr_match !== 1'b0) begin bad++; $display("FAIL write_match_stop: got %b want 0", addr_match); end
   endtask

   task automatic test_wrong_addr();
      logic ack;
      int base, am0;
      base = rx_cnt; am0 = am_cnt;
      i2c_start();
      i2c_byte(8'hA2, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL wrong_addr_nack: got ack=%b want 0", ack); end
      i2c_byte(8'hFF, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL wrong_data_nack: got ack=%b want 0", ack); end
      i2c_stop();
      total++; if (rx_cnt !== base) begin bad++; $display("FAIL wrong_rx_count: got %0d want %0d", rx_cnt, base); end
      total++; if (am_cnt !== am0) begin bad++; $display("FAIL wrong_addr_match: got %0d high cycles want 0", am_cnt - am0); end
   endtask

   task automatic test_read_nack();
      logic ack;
      int base;
      base = rx_cnt;
      i2c_start();
      i2c_byte(8'hA1, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL read_nack: got ack=%b want 0", ack); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy: got %b want 1", busy); end
      total++; if (addr_match !== 1'b0) begin bad++; $display("FAIL read_match: got %b want 0", addr_match); end
      i2c_byte(8'h00, ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL read_ignore_nack: got ack=%b want 0", ack); end
      i2c_stop();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy_stop: got %b want 0", busy); end
      total++; if (rx_cnt !== base) begin bad++; $display("FAIL read_rx_count: got %0d want %0d", rx_cnt, base); end
   endtask

   task automatic test_burst();
      logic ack;
      logic [7:0] exp_b;
      int base;
      base = rx_cnt;
      i2c_start();
      i2c_byte(8'hA0, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL burst_addr_ack: got %b want 1", ack); end
      for (int k = 1; k <= 3; k++) begin
         i2c_byte(8'(k), ack);
         total++; if (ack !== 1'b1) begin bad++; $display("FAIL burst_data_ack%0d: got %b want 1", k, ack); end
      end
      i2c_stop();
      total++; if (rx_cnt - base !== 3) begin bad++; $display("FAIL burst_rx_count: got %0d want 3", rx_cnt - base); end
      for (int k = 0; k < 3; k++) begin
         exp_b = 8'(k + 1);
         if (base + k < rx_cnt) begin
            total++; if (rx_log[base + k] !== exp_b) begin bad++; $display("FAIL burst_byte%0d: got %h want %h", k, rx_log[base + k], exp_b); end
         end
      end
   endtask

   task automatic test_partial_stop();
      logic ack;
      int base;
      base = rx_cnt;
      i2c_start();
      i2c_byte(8'hA0, ack);
      i2c_bits(8'hF0, 7, 4);
      i2c_stop();
      total++; if (rx_cnt !== base) begin bad++; $display("FAIL partial_rx_count: got %0d want %0d", rx_cnt, base); end
      total++; if (rx_data !== 8'h03) begin bad++; $display("FAIL partial_rx_data: got %h want 03", rx_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL partial_busy: got %b want 0", busy); end
      i2c_start();
      i2c_byte(8'hA0, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL partial_readdr_ack: got %b want 1", ack); end
      i2c_stop();
   endtask

   task automatic test_repeated_start();
      logic ack;
      int base;
      base = rx_cnt;
      i2c_start();
      i2c_byte(8'hA0, ack);
      i2c_byte(8'h11, ack);
      i2c_start();
      total++; if (addr_match !== 1'b0) begin bad++; $display("FAIL rstart_match: got %b want 0", addr_match); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstart_busy: got %b want 1", busy); end
      i2c_byte(8'hA0, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL rstart_addr_ack: got %b want 1", ack); end
      i2c_byte(8'h22, ack);
      i2c_stop();
      total++; if (rx_cnt - base !== 2) begin bad++; $display("FAIL rstart_rx_count: got %0d want 2", rx_cnt - base); end
      total++; if (rx_data !== 8'h22) begin bad++; $display("FAIL rstart_rx_data: got %h want 22", rx_data); end
   endtask

   task automatic test_reset_in_ack();
      logic ack;
      i2c_start();
      i2c_byte(8'hA0, ack);
      i2c_bits(8'h99, 7, 0);
      m_sda = 1'b1;
      @(negedge clk);
      total++; if (sda !== 1'b0) begin bad++; $display("FAIL rst_ack_driven: got sda=%b want 0", sda); end
      reset = 1'b1;
      #1;
      total++; if (sda !== 1'b1) begin bad++; $display("FAIL rst_sda_release: got sda=%b want 1", sda); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
      total++; if (addr_match !== 1'b0) begin bad++; $display("FAIL rst_addr_match: got %b want 0", addr_match); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      repeat (3) @(negedge clk);
      scl = 1'b1;
      wq();
      reset = 1'b0;
      wq();
   endtask

`ifdef I2C_SLV_GLITCH_FILTER_EN
   task automatic test_glitch();
      logic ack;
      i2c_start();
      i2c_byte(8'hA0, ack);
      i2c_bits(8'h5A, 7, 4);
      @(posedge clk); #1 scl = 1'b1;
      @(posedge clk); #1 scl = 1'b0;
      i2c_bits(8'h5A, 3, 0);
      i2c_ack(ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL glitch_ack: got %b want 1", ack); end
      i2c_stop();
      total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL glitch_rx_data: got %h want 5a", rx_data); end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_wrong_addr();
      test_read_nack();
      test_burst();
      test_partial_stop();
      test_repeated_start();
      test_reset_in_ack();
`ifdef I2C_SLV_GLITCH_FILTER_EN
      test_glitch();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
